// File: rtl/ps2_scancode_decoder.sv
// PS/2 scan-code decoder: validates raw 11-bit frames, folds E0/F0 prefixes into
// {ext, rel, code} events and queues them in a 4-entry FIFO with sticky error status.
module ps2_scancode_decoder (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] frame,
  input  logic        frame_valid,
  output logic [7:0]  ev_code,
  output logic        ev_ext,
  output logic        ev_rel,
  output logic        ev_valid,
  input  logic        ev_ready,
  output logic        frame_err,
  output logic        overflow,
  output logic [7:0]  err_count,
  input  logic        err_clr
);

  localparam int unsigned DEPTH = 4;
  localparam logic [7:0]  CODE_EXT = 8'hE0;
  localparam logic [7:0]  CODE_BRK = 8'hF0;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXT     = 2'd1,
    S_BRK     = 2'd2,
    S_EXT_BRK = 2'd3
  } state_t;

  state_t state_reg, state_next;

  logic [7:0] rx_byte;
  logic       frame_ok;
  logic       push_req;
  logic       bad_frame;
  logic [9:0] push_data;

  logic [1:0] wr_ptr_reg, wr_ptr_next;
  logic [1:0] rd_ptr_reg, rd_ptr_next;
  logic [2:0] count_reg, count_next;
  logic       fifo_full;
  logic       pop;
  logic       do_write;
  logic       drop;

  logic       frame_err_reg, frame_err_next;
  logic       overflow_reg, overflow_next;
  logic [7:0] err_count_reg, err_count_next;

  logic [DEPTH-1:0][9:0] entries;
  logic [9:0]            head;

  // Frame qualification: start low, stop high, odd parity over data + parity bit.
  assign rx_byte  = frame[8:1];
  assign frame_ok = ~frame[0] & frame[10] & (^frame[9:1]);

  // ---------------------------------------------------------------------------
  // Prefix FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    push_req   = 1'b0;
    bad_frame  = 1'b0;
    push_data  = {
      (state_reg == S_EXT) || (state_reg == S_EXT_BRK),
      (state_reg == S_BRK) || (state_reg == S_EXT_BRK),
      rx_byte
    };
    if (frame_valid) begin
      if (!frame_ok) begin
        bad_frame  = 1'b1;
        state_next = S_IDLE;
      end else if (rx_byte == CODE_EXT) begin
        state_next = S_EXT;
      end else if (rx_byte == CODE_BRK) begin
        case (state_reg)
          S_IDLE:  state_next = S_BRK;
          S_EXT:   state_next = S_EXT_BRK;
          default: state_next = state_reg;
        endcase
      end else begin
        push_req   = 1'b1;
        state_next = S_IDLE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Event FIFO
  // ---------------------------------------------------------------------------
  assign fifo_full = (count_reg == 3'(DEPTH));
  assign pop       = (count_reg != 3'd0) && ev_ready;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts a push.
  assign do_write  = push_req && (!fifo_full || pop);
  assign drop      = push_req && fifo_full && !pop;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [9:0] entry_reg;
      always_ff @(posedge clk) begin
        if (do_write && (wr_ptr_reg == 2'(gi))) begin
          entry_reg <= push_data;
        end
      end
      assign entries[gi] = entry_reg;
    end
  endgenerate

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (do_write) begin
      wr_ptr_next = wr_ptr_reg + 2'd1;
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + 2'd1;
    end
    case ({do_write, pop})
      2'b10:   count_next = count_reg + 3'd1;
      2'b01:   count_next = count_reg - 3'd1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= 2'd0;
      rd_ptr_reg <= 2'd0;
      count_reg  <= 3'd0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  assign head     = entries[rd_ptr_reg];
  assign ev_ext   = head[9];
  assign ev_rel   = head[8];
  assign ev_code  = head[7:0];
  assign ev_valid = (count_reg != 3'd0);

  // ---------------------------------------------------------------------------
  // Sticky error status; a clear wins over an error arriving in the same cycle
  // ---------------------------------------------------------------------------
  always_comb begin
    frame_err_next = frame_err_reg;
    overflow_next  = overflow_reg;
    err_count_next = err_count_reg;
    if (err_clr) begin
      frame_err_next = 1'b0;
      overflow_next  = 1'b0;
      err_count_next = 8'd0;
    end else begin
      if (bad_frame) begin
        frame_err_next = 1'b1;
        if (err_count_reg != 8'hFF) begin
          err_count_next = err_count_reg + 8'd1;
        end
      end
      if (drop) begin
        overflow_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_err_reg <= 1'b0;
      overflow_reg  <= 1'b0;
      err_count_reg <= 8'd0;
    end else begin
      frame_err_reg <= frame_err_next;
      overflow_reg  <= overflow_next;
      err_count_reg <= err_count_next;
    end
  end

  assign frame_err = frame_err_reg;
  assign overflow  = overflow_reg;
  assign err_count = err_count_reg;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Randomized self-checking bench for ps2_scancode_decoder against a queue-based
// model of the prefix/event rules, plus directed boundary sequences.
module tb_ps2_scancode_decoder;

  logic        clk;
  logic        reset;
  logic [10:0] frame;
  logic        frame_valid;
  logic [7:0]  ev_code;
  logic        ev_ext;
  logic        ev_rel;
  logic        ev_valid;
  logic        ev_ready;
  logic        frame_err;
  logic        overflow;
  logic [7:0]  err_count;
  logic        err_clr;

  int unsigned n_compared = 0;
  int unsigned n_mismatched = 0;

  // Model state: pending prefix flags, event queue and status.
  logic [9:0]  mq[$];
  bit          m_ext, m_rel;
  bit          m_ferr, m_ovf;
  int unsigned m_ecnt;

  ps2_scancode_decoder dut (
    .clk        (clk),
    .reset      (reset),
    .frame      (frame),
    .frame_valid(frame_valid),
    .ev_code    (ev_code),
    .ev_ext     (ev_ext),
    .ev_rel     (ev_rel),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .frame_err  (frame_err),
    .overflow   (overflow),
    .err_count  (err_count),
    .err_clr    (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // kind: 0 good, 1 parity flipped, 2 start high, 3 stop low
  function automatic logic [10:0] mk(input logic [7:0] c, input int kind);
    logic [10:0] f;
    f = {1'b1, ~(^c), c, 1'b0};
    case (kind)
      1: f[9]  = ~f[9];
      2: f[0]  = 1'b1;
      3: f[10] = 1'b0;
      default: ;
    endcase
    return f;
  endfunction

  task automatic model_apply(input logic rst, input logic fv, input logic [10:0] f,
                             input logic rdy, input logic clr);
    bit ok, err, push, drop, popped;
    int unsigned occ;
    logic [7:0] c;
    logic [9:0] ev;
    if (rst) begin
      mq.delete();
      m_ext = 0; m_rel = 0; m_ferr = 0; m_ovf = 0; m_ecnt = 0;
      return;
    end
    ok = (f[0] == 1'b0) && (f[10] == 1'b1) && ($countones(f[9:1]) % 2 == 1);
    c = f[8:1];
    err = 0; push = 0; drop = 0;
    ev = '0;
    if (fv) begin
      if (!ok) begin
        err = 1; m_ext = 0; m_rel = 0;
      end else if (c == 8'hE0) begin
        m_ext = 1; m_rel = 0;
      end else if (c == 8'hF0) begin
        m_rel = 1;
      end else begin
        push = 1; ev = {m_ext, m_rel, c};
        m_ext = 0; m_rel = 0;
      end
    end
    occ = mq.size();
    popped = (occ > 0) && rdy;
    if (popped) begin
      $display("pop code=%02h ext=%0d rel=%0d", mq[0][7:0], mq[0][9], mq[0][8]);
      void'(mq.pop_front());
    end
    if (push) begin
      if (occ < 4 || popped) mq.push_back(ev);
      else drop = 1;
    end
    if (clr) begin
      m_ferr = 0; m_ovf = 0; m_ecnt = 0;
    end else begin
      if (err) begin
        m_ferr = 1;
        if (m_ecnt < 255) m_ecnt++;
      end
      if (drop) m_ovf = 1;
    end
  endtask

  task automatic compare_all();
    check("ev_valid", ev_valid, (mq.size() != 0));
    if (mq.size() != 0) begin
      check("ev_code", ev_code, mq[0][7:0]);
      check("ev_ext",  ev_ext,  mq[0][9]);
      check("ev_rel",  ev_rel,  mq[0][8]);
    end
    check("frame_err", frame_err, m_ferr);
    check("overflow",  overflow,  m_ovf);
    check("err_count", err_count, m_ecnt);
  endtask

  task automatic step(input logic rst, input logic fv, input logic [10:0] f,
                      input logic rdy, input logic clr);
    reset = rst; frame_valid = fv; frame = f; ev_ready = rdy; err_clr = clr;
    model_apply(rst, fv, f, rdy, clr);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic send(input logic [7:0] c, input int kind, input logic rdy);
    step(1'b0, 1'b1, mk(c, kind), rdy, 1'b0);
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 1'b0, 11'h0, rdy, 1'b0);
  endtask

  initial begin
    logic [7:0] rc;
    int         kind;
    int         r;
    reset = 1'b1; frame = '0; frame_valid = 0; ev_ready = 0; err_clr = 0;
    step(1'b1, 1'b0, 11'h0, 1'b0, 1'b0);
    step(1'b1, 1'b1, mk(8'h1C, 1), 1'b1, 1'b1);
    check("reset_valid", ev_valid, 0);

    // Single make code, then pop.
    send(8'h1C, 0, 1'b0);
    check("a_code", ev_code, 8'h1C);
    check("a_ext", ev_ext, 0);
    idle(1'b1);
    check("a_popped", ev_valid, 0);

    // Extended release E0 F0 75.
    send(8'hE0, 0, 1'b0);
    send(8'hF0, 0, 1'b0);
    check("ext_none_yet", ev_valid, 0);
    send(8'h75, 0, 1'b0);
    check("ext_code", ev_code, 8'h75);
    check("ext_flags", {ev_ext, ev_rel}, 2'b11);
    idle(1'b1);

    // Parity error then good frame.
    send(8'h1C, 1, 1'b0);
    check("par_cnt", err_count, 1);
    send(8'h1C, 0, 1'b0);
    idle(1'b1);

    // Error clears a pending break prefix.
    send(8'hF0, 0, 1'b0);
    send(8'h1C, 3, 1'b0);
    send(8'h1C, 0, 1'b0);
    check("brk_cleared", ev_rel, 0);
    idle(1'b1);
    step(1'b0, 1'b0, 11'h0, 1'b0, 1'b1);

    // Overflow on fifth event, then drain including one pop on empty.
    send(8'h15, 0, 1'b0);
    send(8'h1D, 0, 1'b0);
    send(8'h24, 0, 1'b0);
    send(8'h2D, 0, 1'b0);
    send(8'h2C, 0, 1'b0);
    check("ovf_set", overflow, 1);
    for (int i = 0; i < 5; i++) idle(1'b1);
    step(1'b0, 1'b0, 11'h0, 1'b0, 1'b1);

    // Full FIFO with simultaneous push and pop.
    send(8'h15, 0, 1'b0);
    send(8'h1D, 0, 1'b0);
    send(8'h24, 0, 1'b0);
    send(8'h2D, 0, 1'b0);
    send(8'h2C, 0, 1'b1);
    check("full_pp_ovf", overflow, 0);
    for (int i = 0; i < 5; i++) idle(1'b1);

    // Reset mid-sequence with queued events and competing inputs.
    send(8'h1C, 0, 1'b0);
    send(8'hE0, 0, 1'b0);
    step(1'b1, 1'b1, mk(8'h33, 0), 1'b1, 1'b1);
    send(8'h1C, 0, 1'b0);
    check("rst_prefix", ev_ext, 0);
    idle(1'b1);

    // Saturate err_count, then clear coincident with another error.
    for (int i = 0; i < 260; i++) step(1'b0, 1'b1, mk(8'h42, (i % 3) + 1), 1'b0, 1'b0);
    check("sat_cnt", err_count, 255);
    step(1'b0, 1'b1, mk(8'h42, 1), 1'b0, 1'b1);
    check("clr_wins", err_count, 0);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 9);
      if (r < 2)      rc = 8'hE0;
      else if (r < 4) rc = 8'hF0;
      else            rc = 8'($urandom_range(0, 255));
      kind = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : 0;
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 9) < 7),
           mk(rc, kind),
           ($urandom_range(0, 9) < 4),
           ($urandom_range(0, 49) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_decoder.md
PS2_SCANCODE_DECODER -- requirements
Module: ps2_scancode_decoder

Interface
REQ-001 SHALL have a single clock; reset is synchronous and active-high. Ports are named clk and reset.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 frame  input  11  raw PS/2 frame from the PS/2 receive FSM:
- bit0 = start (expect 0)
- bits[8:1] = data byte, bit1 = D0
- bit9 = odd parity
- bit10 = stop (expect 1)
REQ-005 frame_valid  input  1  one-cycle strobe; frame is valid only in that cycle.
REQ-006 ev_code  output  8  scan code of the event at the FIFO head.
REQ-007 ev_ext  output  1  head event was E0-prefixed (extended key).
REQ-008 ev_rel  output  1  head event was F0-prefixed (key release / break).
REQ-009 ev_valid  output  1  event FIFO is not empty.
REQ-010 ev_ready  input  1  consumer pops the head event when ev_valid && ev_ready.
REQ-011 frame_err  output  1  sticky flag: a framing or parity error has occurred.
REQ-012 overflow  output  1  sticky flag: an event was dropped because the FIFO was full.
REQ-013 err_count  output  8  saturating count of rejected frames.
REQ-014 err_clr  input  1  clears frame_err, overflow and err_count to 0 on the next edge.

Function
REQ-015 A frame SHALL be valid only when all three hold: start == 0, stop == 1, and the XOR of bits[9:1] == 1 (odd parity).
REQ-016 An invalid frame SHALL:
- set frame_err;
- increment err_count, saturating at 255;
- return the prefix FSM to IDLE, discarding any pending prefix;
- push no event.
REQ-017 The prefix FSM SHALL have exactly four states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 then F0 seen).
REQ-018 On a valid byte 0xE0, the FSM SHALL go to EXT from any state; a repeated E0 is idempotent, and EXT_BRK also goes to EXT.
REQ-019 On a valid byte 0xF0, the FSM SHALL go IDLE->BRK, EXT->EXT_BRK, and hold in BRK or EXT_BRK.
REQ-020 On any other valid byte, the block SHALL push {ext, rel, code} and return to IDLE:
- ext = 1 in EXT or EXT_BRK;
- rel = 1 in BRK or EXT_BRK.
REQ-021 A pushed event SHALL appear at the FIFO outputs with ev_valid high on the cycle after the frame_valid strobe (1-cycle latency when the FIFO was empty).
REQ-022 The event FIFO SHALL be 4 entries deep and 10 bits wide, first-in first-out, with head outputs driven combinationally from the read pointer.
REQ-023 Pointers SHALL be 2 bits with natural wrap-around, plus a 3-bit occupancy count in the range 0..4.
REQ-024 Push with the FIFO full and no pop in the same cycle: the event SHALL be dropped, overflow set, and FIFO contents unchanged; the FSM still returns to IDLE.
REQ-025 Push and pop in the same cycle SHALL both succeed, including when the FIFO is full, with occupancy unchanged.
REQ-026 A pop with the FIFO empty (ev_ready high, ev_valid low) SHALL be ignored.
REQ-027 While ev_valid is low, ev_code/ev_ext/ev_rel SHALL be don't-care; the bench checks them only when ev_valid is high.
REQ-028 err_clr coincident with a new error SHALL clear all three fields; the error in that cycle is not recorded.
REQ-029 A frame_valid strobe in back-to-back cycles SHALL be processed fully each cycle; the block has no busy state.

Reset
REQ-030 On reset the block SHALL set:
- FSM = IDLE;
- read pointer, write pointer and count = 0;
- ev_valid = 0, frame_err = 0, overflow = 0, err_count = 0.
REQ-031 Reset SHALL take priority over frame_valid, ev_ready and err_clr in the same cycle.
REQ-032 Reset mid-sequence, for example after E0 and before the final code, SHALL discard the pending prefix and all queued events.

Verification
REQ-033 Valid frame 0x1C (A) -> next cycle ev_valid = 1, ev_code = 0x1C, ev_ext = 0, ev_rel = 0; pop -> ev_valid = 0.
REQ-034 Sequence E0, F0, 0x75 with no pops -> exactly one event: ev_code = 0x75, ev_ext = 1, ev_rel = 1; FSM back in IDLE.
REQ-035 Frame 0x1C with the parity bit flipped, then a valid 0x1C -> first frame: frame_err = 1, err_count = 1, no event; second frame: one event 0x1C.
REQ-036 Sequence F0, bad-stop frame, 0x1C -> event 0x1C with ev_rel = 0, because the error cleared the prefix.
REQ-037 Five valid codes 0x15, 0x1D, 0x24, 0x2D, 0x2C with no pops -> overflow = 1; pops return 0x15, 0x1D, 0x24, 0x2D, then ev_valid = 0.
REQ-038 FIFO full, then a valid frame with ev_ready = 1 in the same cycle -> overflow stays 0, count stays 4, and the new code appears after the three older entries.
